// File: rtl/seq_stim_pkg.sv
// Shared types and constants for the A/B/C/J/K/X sequence stimulus generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_stim_pkg;

  localparam int MAX_B_DEF  = 3;
  localparam int J_REPS_DEF = 4;
  localparam int NB_W_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_C   = 3'd1,
    S_B   = 3'd2,
    S_A   = 3'd3,
    S_J   = 3'd4,
    S_K   = 3'd5,
    S_X   = 3'd6,
    S_END = 3'd7
  } state_t;

  // Symbol vector bit order: {A, B, C, J, K, X}
  localparam logic [5:0] SYM_NONE = 6'b000000;
  localparam logic [5:0] SYM_A    = 6'b100000;
  localparam logic [5:0] SYM_B    = 6'b010000;
  localparam logic [5:0] SYM_C    = 6'b001000;
  localparam logic [5:0] SYM_J    = 6'b000100;
  localparam logic [5:0] SYM_K    = 6'b000010;
  localparam logic [5:0] SYM_X    = 6'b000001;

endpackage

// File: rtl/seq_rep_cnt.sv
// Loadable down-counter with zero flag, shared by the B and J repetition phases.
// Latency: load/dec take effect on the next posedge CLK; zero is combinational from the count.
// Backpressure: none; saturates at zero instead of wrapping.
// Ports: CLK/RST clock and async active-high reset; load+load_val preset the count;
//        dec decrements by one when nonzero; zero flags count==0.
module seq_rep_cnt #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_stim_gen.sv
// Transmitter emitting C B[*nb] A J[*J_REPS] K one symbol per CLK, with abort (X) and K-drop injection.
// Latency: start accepted at edge n -> C visible after edge n; done pulse nb_eff+J_REPS+3 cycles after C.
// Backpressure: none; start while busy (or in the done cycle) is dropped, never queued.
// Ports: CLK, RST (async active-high); start/nb/drop_k request a sequence; abort kills one in flight;
//        A,B,C,J,K,X symbol outputs; busy, done, aborted status. All outputs registered.
module seq_stim_gen
  import seq_stim_pkg::*;
#(
  parameter int MAX_B  = MAX_B_DEF,
  parameter int J_REPS = J_REPS_DEF,
  parameter int NB_W   = NB_W_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [NB_W-1:0] nb,
  input  logic            drop_k,
  input  logic            abort,
  output logic            A,
  output logic            B,
  output logic            C,
  output logic            J,
  output logic            K,
  output logic            X,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  localparam int CNT_MAX = (MAX_B > J_REPS) ? MAX_B : J_REPS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [NB_W-1:0]  MAX_B_V  = NB_W'(MAX_B);
  localparam logic [CNT_W-1:0] J_LOAD   = CNT_W'(J_REPS - 1);

  state_t            state, state_nxt;
  logic [NB_W-1:0]   nb_lat;
  logic              drop_lat;
  logic [NB_W-1:0]   nb_eff;
  logic              accept;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_zero;

  logic [5:0]        sym_q, sym_nxt;
  logic              busy_nxt, done_nxt, aborted_nxt;

  // Clamp requested B count into 1..MAX_B.
  always_comb begin
    nb_eff = nb;
    if (nb == '0) begin
      nb_eff = NB_W'(1);
    end else if (nb > MAX_B_V) begin
      nb_eff = MAX_B_V;
    end
  end

  assign accept = (state == IDLE) && start;

  seq_rep_cnt #(.W(CNT_W)) u_rep_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      nb_lat   <= '0;
      drop_lat <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        nb_lat   <= nb_eff;
        drop_lat <= drop_k;
      end
    end
  end

  // The counter is preset on the cycle before a repeat phase so the phase
  // lasts exactly load_val+1 cycles and exits on the zero flag.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = S_C;
      S_C: begin
        state_nxt = S_B;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(nb_lat - 1'b1);
      end
      S_B: begin
        if (cnt_zero) state_nxt = S_A;
        else          cnt_dec   = 1'b1;
      end
      S_A: begin
        state_nxt = S_J;
        cnt_load  = 1'b1;
        cnt_val   = J_LOAD;
      end
      S_J: begin
        if (cnt_zero) state_nxt = S_K;
        else          cnt_dec   = 1'b1;
      end
      S_K:   state_nxt = S_END;
      S_X:   state_nxt = IDLE;
      S_END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every in-flight transition, including S_K -> S_END.
    if (abort && (state inside {S_C, S_B, S_A, S_J, S_K})) begin
      state_nxt = S_X;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    sym_nxt     = SYM_NONE;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    case (state_nxt)
      S_C:   begin sym_nxt = SYM_C; busy_nxt = 1'b1; end
      S_B:   begin sym_nxt = SYM_B; busy_nxt = 1'b1; end
      S_A:   begin sym_nxt = SYM_A; busy_nxt = 1'b1; end
      S_J:   begin sym_nxt = SYM_J; busy_nxt = 1'b1; end
      S_K:   begin sym_nxt = drop_lat ? SYM_NONE : SYM_K; busy_nxt = 1'b1; end
      S_X:   begin sym_nxt = SYM_X; busy_nxt = 1'b1; end
      S_END: done_nxt = 1'b1;
      default: sym_nxt = SYM_NONE;
    endcase
    if ((state == S_X) && (state_nxt == IDLE)) begin
      aborted_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sym_q   <= SYM_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      sym_q   <= sym_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      aborted <= aborted_nxt;
    end
  end

  assign {A, B, C, J, K, X} = sym_q;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Scoreboard bench for seq_stim_gen: stimulus pushes expected output vectors, a monitor pops and compares.
// Latency: monitor samples 3 time units after each posedge CLK.
// Backpressure: n/a.
module tb_seq_stim_gen;
  import seq_stim_pkg::*;

  // Vector order: {A,B,C,J,K,X,busy,done,aborted}
  localparam logic [8:0] V_IDLE = 9'b000000_000;
  localparam logic [8:0] V_A    = 9'b100000_100;
  localparam logic [8:0] V_B    = 9'b010000_100;
  localparam logic [8:0] V_C    = 9'b001000_100;
  localparam logic [8:0] V_J    = 9'b000100_100;
  localparam logic [8:0] V_K    = 9'b000010_100;
  localparam logic [8:0] V_X    = 9'b000001_100;
  localparam logic [8:0] V_KD   = 9'b000000_100;
  localparam logic [8:0] V_DONE = 9'b000000_010;
  localparam logic [8:0] V_ABT  = 9'b000000_001;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] nb = 2'd0;
  logic       drop_k = 1'b0;
  logic       abort = 1'b0;

  logic A1, B1, C1, J1, K1, X1, busy1, done1, aborted1;
  logic A2, B2, C2, J2, K2, X2, busy2, done2, aborted2;
  logic [8:0] v1, v2;

  logic [8:0] q1[$];
  logic [8:0] q2[$];
  int vectors = 0;
  int misc    = 0;

  always #5 CLK = ~CLK;

  seq_stim_gen #(.MAX_B(3), .J_REPS(4), .NB_W(2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .nb(nb), .drop_k(drop_k), .abort(abort),
    .A(A1), .B(B1), .C(C1), .J(J1), .K(K1), .X(X1),
    .busy(busy1), .done(done1), .aborted(aborted1)
  );

  seq_stim_gen #(.MAX_B(2), .J_REPS(4), .NB_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .nb(nb), .drop_k(drop_k), .abort(abort),
    .A(A2), .B(B2), .C(C2), .J(J2), .K(K2), .X(X2),
    .busy(busy2), .done(done2), .aborted(aborted2)
  );

  assign v1 = {A1, B1, C1, J1, K1, X1, busy1, done1, aborted1};
  assign v2 = {A2, B2, C2, J2, K2, X2, busy2, done2, aborted2};

  task automatic push(input int which, input logic [8:0] v);
    if (which == 1) q1.push_back(v);
    else            q2.push_back(v);
  endtask

  // Full sequence with a hand-supplied effective B count.
  task automatic push_seq(input int which, input int nbe, input bit drop);
    push(which, V_C);
    for (int i = 0; i < nbe; i++) push(which, V_B);
    push(which, V_A);
    for (int i = 0; i < 4; i++) push(which, V_J);
    push(which, drop ? V_KD : V_K);
    push(which, V_DONE);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      misc++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (((q1.size() != 0) || (q2.size() != 0)) && (n < budget)) begin
      @(negedge CLK);
      n++;
    end
    if ((q1.size() != 0) || (q2.size() != 0)) begin
      vectors++;
      misc++;
      $display("FAIL %s: drain timeout, %0d/%0d vectors left, expected 0", name, q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
    @(negedge CLK);
  endtask

  // Monitor: compare DUT outputs against queued expectations every cycle.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge CLK);
      #3;
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("dut_vec", v1, e);
      end
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("dut2_vec", v2, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 3 cycles.
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", v1, V_IDLE);
    check("reset_outputs_dut2", v2, V_IDLE);
    @(negedge CLK);
    RST = 1'b0;
    push(1, V_IDLE); push(1, V_IDLE);
    wait_drain("post_reset", 10);

    // nb=1: C,B,A,J*4,K, done 9th cycle.
    start = 1'b1; nb = 2'd1; drop_k = 1'b0;
    push_seq(1, 1, 1'b0);
    push(1, V_IDLE);
    @(negedge CLK); start = 1'b0;
    wait_drain("nb1", 30);

    // nb=3 with a start pulse mid-sequence that must be ignored.
    start = 1'b1; nb = 2'd3;
    push_seq(1, 3, 1'b0);
    push(1, V_IDLE); push(1, V_IDLE);
    @(negedge CLK); start = 1'b0;
    repeat (2) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK); start = 1'b0;
    wait_drain("nb3", 30);

    // nb=0 behaves as nb=1; abort alongside start in IDLE is ignored.
    start = 1'b1; nb = 2'd0; abort = 1'b1;
    push_seq(1, 1, 1'b0);
    push(1, V_IDLE);
    @(negedge CLK); start = 1'b0; abort = 1'b0;
    wait_drain("nb0_abort_idle", 30);

    // Abort alone in IDLE does nothing.
    abort = 1'b1;
    push(1, V_IDLE); push(1, V_IDLE);
    @(negedge CLK); abort = 1'b0;
    wait_drain("abort_in_idle", 10);

    // MAX_B=2 instance clamps nb=3 to two B cycles.
    start2 = 1'b1; nb = 2'd3;
    push_seq(2, 2, 1'b0);
    push(2, V_IDLE);
    push(1, V_IDLE);
    @(negedge CLK); start2 = 1'b0;
    wait_drain("maxb2_clamp", 30);

    // nb=2, abort during the second J cycle.
    start = 1'b1; nb = 2'd2;
    push(1, V_C); push(1, V_B); push(1, V_B); push(1, V_A);
    push(1, V_J); push(1, V_J); push(1, V_X); push(1, V_ABT);
    push(1, V_IDLE); push(1, V_IDLE);
    @(negedge CLK); start = 1'b0;
    repeat (5) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    wait_drain("abort_2nd_j", 30);

    // Abort during K beats completion.
    start = 1'b1; nb = 2'd1;
    push(1, V_C); push(1, V_B); push(1, V_A);
    for (int i = 0; i < 4; i++) push(1, V_J);
    push(1, V_K); push(1, V_X); push(1, V_ABT); push(1, V_IDLE);
    @(negedge CLK); start = 1'b0;
    repeat (7) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    wait_drain("abort_in_k", 30);

    // drop_k: K cycle all symbols low, done still pulses.
    start = 1'b1; nb = 2'd1; drop_k = 1'b1;
    push_seq(1, 1, 1'b1);
    push(1, V_IDLE);
    @(negedge CLK); start = 1'b0; drop_k = 1'b0;
    wait_drain("drop_k", 30);

    // start held: second sequence only after an IDLE cycle following done.
    start = 1'b1; nb = 2'd1;
    push_seq(1, 1, 1'b0);
    push(1, V_IDLE);
    push_seq(1, 1, 1'b0);
    push(1, V_IDLE); push(1, V_IDLE);
    repeat (19) @(negedge CLK);
    start = 1'b0;
    wait_drain("start_held", 40);

    // Reset asserted during J clears outputs immediately.
    start = 1'b1; nb = 2'd1;
    push(1, V_C); push(1, V_B); push(1, V_A); push(1, V_J);
    @(negedge CLK); start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midreset_outputs", v1, V_IDLE);
    vectors++;
    if (dut.state != IDLE) begin
      misc++;
      $display("FAIL midreset_state: got %0d expected %0d", dut.state, IDLE);
    end
    @(negedge CLK);
    RST = 1'b0;
    push(1, V_IDLE); push(1, V_IDLE); push(1, V_IDLE);
    wait_drain("post_midreset", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
